contador_programa: RTL and testbench

Program-counter and fetch-sequencing stage sitting directly upstream of the control unit: it holds the PC that addresses instruction memory, applies the control unit's branch/jump/halt/context decisions each cycle, and generates the one-cycle `sinal` pulse that completes `in`/`out` instructions. A user button is synchronised and edge-detected internally. The block consumes `desvio`, `stop`, `endProgram`, `nextProgram`, `lpc` and `spc`, and supplies `pc` and `pc_mais_um` (the `jal` link value).

---
 rtl/contador_programa_if.sv | 34 +++
 rtl/contador_programa.sv | 123 ++++++++++++
 tb/tb_contador_programa.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/contador_programa_if.sv
// contador_programa_if: control unit <-> PC stage signal bundle.
// master = control unit side, slave = contador_programa.
interface contador_programa_if #(
  parameter int LARG_END = 10
);
  logic [2:0]          desvio;
  logic                zero;
  logic                negativo;
  logic [LARG_END-1:0] imediato;
  logic [31:0]         dado_reg;
  logic                stop;
  logic                endProgram;
  logic                nextProgram;
  logic                lpc;
  logic                spc;
  logic                botao;
  logic [LARG_END-1:0] pc;
  logic [LARG_END-1:0] pc_mais_um;
  logic                sinal;
  logic                parado;
  logic [LARG_END-1:0] pc_salvo;

  modport master (
    output desvio, zero, negativo, imediato, dado_reg,
    output stop, endProgram, nextProgram, lpc, spc, botao,
    input  pc, pc_mais_um, sinal, parado, pc_salvo
  );

  modport slave (
    input  desvio, zero, negativo, imediato, dado_reg,
    input  stop, endProgram, nextProgram, lpc, spc, botao,
    output pc, pc_mais_um, sinal, parado, pc_salvo
  );
endinterface

// File: rtl/contador_programa.sv
// contador_programa: PC register and fetch sequencing (run/wait/halt).
// Define CONTEXTO_EN to build the saved-context PC (spc/lpc/nextProgram).
module contador_programa #(
  parameter int LARG_END    = 10,
  parameter int END_INICIAL = 0
) (
  input logic                clock,
  input logic                reset,
  contador_programa_if.slave bus
);
  typedef enum logic [1:0] {
    EXECUTA,
    ESPERA,
    PARADO
  } estado_t;

  estado_t             estado, estado_nx;
  logic [LARG_END-1:0] pc_q, pc_nx;
  logic [LARG_END-1:0] mais_um;
  logic [LARG_END-1:0] salvo;
  logic [LARG_END-1:0] dado_lo;
  logic                sinal_q, sinal_nx;
  logic [2:0]          sinc;
  logic                subida;
  logic                tomado;
  logic                ctx_next, ctx_lpc, ctx_spc;
  logic                unused_dado;

  assign mais_um        = pc_q + LARG_END'(1);
  assign dado_lo        = bus.dado_reg[LARG_END-1:0];
  assign unused_dado    = ^bus.dado_reg;
  assign bus.pc         = pc_q;
  assign bus.pc_mais_um = mais_um;
  assign bus.sinal      = sinal_q;
  assign bus.parado     = (estado == PARADO);

  // sinc[1:0] synchronise botao, sinc[2] is the edge-detect history
  assign subida = sinc[1] & ~sinc[2];

`ifdef CONTEXTO_EN
  logic [LARG_END-1:0] salvo_q;

  assign ctx_next     = bus.nextProgram;
  assign ctx_lpc      = bus.lpc;
  assign ctx_spc      = bus.spc;
  assign salvo        = salvo_q;
  assign bus.pc_salvo = salvo_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      salvo_q <= '0;
    else if (estado == EXECUTA && ctx_spc)
      salvo_q <= mais_um;
  end
`else
  logic unused_ctx;

  assign unused_ctx   = bus.spc ^ bus.lpc ^ bus.nextProgram;
  assign ctx_next     = 1'b0;
  assign ctx_lpc      = 1'b0;
  assign ctx_spc      = 1'b0;
  assign salvo        = '0;
  assign bus.pc_salvo = '0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado  <= EXECUTA;
      pc_q    <= LARG_END'(END_INICIAL);
      sinal_q <= 1'b0;
      sinc    <= '0;
    end else begin
      estado  <= estado_nx;
      pc_q    <= pc_nx;
      sinal_q <= sinal_nx;
      sinc    <= {sinc[1:0], bus.botao};
    end
  end

  always_comb begin
    tomado = 1'b0;
    unique case (bus.desvio)
      3'b001:  tomado = 1'b1;
      3'b010:  tomado = bus.zero;
      3'b100:  tomado = ~bus.zero;
      3'b101:  tomado = bus.negativo;
      3'b110:  tomado = bus.negativo | bus.zero;
      default: tomado = 1'b0;
    endcase
  end

  always_comb begin
    estado_nx = estado;
    pc_nx     = pc_q;
    sinal_nx  = 1'b0;
    unique case (estado)
      EXECUTA: begin
        if (bus.endProgram)
          estado_nx = PARADO;
        else if (bus.stop)
          estado_nx = ESPERA;
        else if (ctx_next)
          pc_nx = salvo;
        else if (ctx_lpc)
          pc_nx = dado_lo;
        else if (bus.desvio == 3'b011)
          pc_nx = dado_lo;
        else if (tomado)
          pc_nx = bus.imediato;
        else
          pc_nx = mais_um;
      end
      ESPERA: begin
        if (subida) begin
          sinal_nx  = 1'b1;
          estado_nx = EXECUTA;
        end
      end
      PARADO:  estado_nx = PARADO;
      default: estado_nx = EXECUTA;
    endcase
  end
endmodule

// File: tb/tb_contador_programa.sv
// tb_contador_programa: directed table, corner sequences and random
// stimulus checked against a behavioural model of the PC stage.
module tb_contador_programa;
  localparam int LE = 10;
  localparam int M  = 1 << LE;
`ifdef CONTEXTO_EN
  localparam bit CTX = 1'b1;
`else
  localparam bit CTX = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  always #5 clock = ~clock;

  contador_programa_if #(.LARG_END(LE)) bus ();
  contador_programa_if #(.LARG_END(4))  bus4 ();

  contador_programa #(.LARG_END(LE), .END_INICIAL(0)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  contador_programa #(.LARG_END(4), .END_INICIAL(0)) dut4 (
    .clock(clock),
    .reset(reset),
    .bus  (bus4)
  );

  int m_pc;
  int m_saved;
  bit m_halt;
  bit m_wait;
  bit m_sinal;
  bit bh [3];

  typedef struct {
    string       nm;
    int          start;
    logic [2:0]  desvio;
    bit          zero;
    bit          neg;
    int          imm;
    logic [31:0] dado;
    int          exp;
  } vec_t;

  vec_t tab[$];

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_saved = 0;
    m_halt = 0; m_wait = 0; m_sinal = 0;
    bh[0] = 0; bh[1] = 0; bh[2] = 0;
  endtask

  task automatic model_edge();
    bit rise;
    bit tk;
    int nxt;
    int dlo;
    int new_pc;
    rise   = bh[1] && !bh[2];
    nxt    = (m_pc + 1) % M;
    dlo    = int'(bus.dado_reg) & (M - 1);
    new_pc = m_pc;
    m_sinal = 0;
    if (m_halt) begin
    end else if (m_wait) begin
      if (rise) begin
        m_sinal = 1;
        m_wait  = 0;
      end
    end else begin
      case (bus.desvio)
        3'd1:    tk = 1;
        3'd2:    tk = bus.zero;
        3'd4:    tk = !bus.zero;
        3'd5:    tk = bus.negativo;
        3'd6:    tk = bus.negativo || bus.zero;
        default: tk = 0;
      endcase
      if (bus.endProgram)              m_halt = 1;
      else if (bus.stop)               m_wait = 1;
      else if (CTX && bus.nextProgram) new_pc = m_saved;
      else if (CTX && bus.lpc)         new_pc = dlo;
      else if (bus.desvio == 3'd3)     new_pc = dlo;
      else if (tk)                     new_pc = int'(bus.imediato);
      else                             new_pc = nxt;
      if (CTX && bus.spc) m_saved = nxt;
    end
    m_pc  = new_pc;
    bh[2] = bh[1];
    bh[1] = bh[0];
    bh[0] = bus.botao;
  endtask

  task automatic cmp_all();
    chk("pc", int'(bus.pc), m_pc);
    chk("pc_mais_um", int'(bus.pc_mais_um), (m_pc + 1) % M);
    chk("sinal", int'(bus.sinal), int'(m_sinal));
    chk("parado", int'(bus.parado), int'(m_halt));
    chk("pc_salvo", int'(bus.pc_salvo), m_saved);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
    cmp_all();
    @(negedge clock);
  endtask

  task automatic clear_inputs();
    bus.desvio = 0; bus.zero = 0; bus.negativo = 0;
    bus.imediato = 0; bus.dado_reg = 0;
    bus.stop = 0; bus.endProgram = 0; bus.nextProgram = 0;
    bus.lpc = 0; bus.spc = 0;
    bus4.desvio = 0; bus4.zero = 0; bus4.negativo = 0;
    bus4.imediato = 0; bus4.dado_reg = 0;
    bus4.stop = 0; bus4.endProgram = 0; bus4.nextProgram = 0;
    bus4.lpc = 0; bus4.spc = 0; bus4.botao = 0;
  endtask

  task automatic set_pc(int v);
    bus.desvio   = 3'b001;
    bus.imediato = LE'(v);
    tick();
    clear_inputs();
  endtask

  task automatic reset_pulse();
    #2 reset = 1'b0;
    model_reset();
    #1 cmp_all();
    #1 reset = 1'b1;
  endtask

  task automatic addv(string nm, int st, logic [2:0] d, bit z, bit n,
                      int imm, logic [31:0] dado, int exp);
    vec_t v;
    v.nm = nm; v.start = st; v.desvio = d; v.zero = z; v.neg = n;
    v.imm = imm; v.dado = dado; v.exp = exp;
    tab.push_back(v);
  endtask

  task automatic wait_sinal(string nm, int exp_k);
    int k_at;
    k_at = 0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (bus.sinal) begin
        k_at = k;
        break;
      end
    end
    chk(nm, k_at, exp_k);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clear_inputs();
    bus.botao = 0;
    model_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #11;
    chk("rst_pc", int'(bus.pc), 0);
    chk("rst_sinal", int'(bus.sinal), 0);
    chk("rst_parado", int'(bus.parado), 0);
    chk("rst_salvo", int'(bus.pc_salvo), 0);
    chk("rst_pc4", int'(bus4.pc), 0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("count", int'(bus.pc), i);
    end
    #2 reset = 1'b0;
    model_reset();
    #1 chk("async_rst_pc", int'(bus.pc), 0);
    @(negedge clock);
    reset = 1'b1;

    addv("beq_taken",   5,    3'b010, 1, 0, 40,  0,            40);
    addv("beq_fall",    5,    3'b010, 0, 0, 40,  0,            6);
    addv("jr",          5,    3'b011, 0, 0, 40,  32'h123,      'h123);
    addv("jr_hibits",   5,    3'b011, 0, 0, 40,  32'hFFFFF123, 'h123);
    addv("bne_taken",   10,   3'b100, 0, 0, 77,  0,            77);
    addv("bne_fall",    10,   3'b100, 1, 0, 77,  0,            11);
    addv("bneg_taken",  12,   3'b101, 0, 1, 3,   0,            3);
    addv("bneg_fall",   12,   3'b101, 0, 0, 3,   0,            13);
    addv("ble_zero",    14,   3'b110, 1, 0, 500, 0,            500);
    addv("ble_neg",     14,   3'b110, 0, 1, 500, 0,            500);
    addv("ble_fall",    14,   3'b110, 0, 0, 500, 0,            15);
    addv("nobr_000",    20,   3'b000, 1, 1, 99,  0,            21);
    addv("nobr_111",    20,   3'b111, 1, 1, 99,  0,            21);
    addv("wrap",        1023, 3'b000, 0, 0, 0,   0,            0);
    addv("jmp",         30,   3'b001, 0, 0, 900, 0,            900);
    foreach (tab[i]) begin
      set_pc(tab[i].start);
      bus.desvio   = tab[i].desvio;
      bus.zero     = tab[i].zero;
      bus.negativo = tab[i].neg;
      bus.imediato = LE'(tab[i].imm);
      bus.dado_reg = tab[i].dado;
      tick();
      chk(tab[i].nm, int'(bus.pc), tab[i].exp);
      clear_inputs();
    end

    set_pc(7);
    bus.stop     = 1;
    bus.desvio   = 3'b001;
    bus.imediato = 100;
    repeat (10) begin
      tick();
      chk("stop_pc", int'(bus.pc), 7);
      chk("stop_sinal", int'(bus.sinal), 0);
    end
    bus.botao = 1;
    wait_sinal("sinal_latency", 3);
    clear_inputs();
    tick();
    chk("resume_pc", int'(bus.pc), 8);
    chk("sinal_width", int'(bus.sinal), 0);

    bus.stop = 1;
    repeat (6) begin
      tick();
      chk("held_no_sinal", int'(bus.sinal), 0);
    end
    bus.botao = 0;
    repeat (2) tick();
    bus.botao = 1;
    wait_sinal("repress_sinal", 3);
    clear_inputs();
    bus.botao = 0;
    tick();
    chk("repress_pc", int'(bus.pc), 9);

    bus4.desvio   = 3'b001;
    bus4.imediato = 4'd15;
    tick();
    chk("l4_pc15", int'(bus4.pc), 15);
    chk("l4_mais_um", int'(bus4.pc_mais_um), 0);
    bus4.desvio = 3'b000;
    tick();
    chk("l4_wrap", int'(bus4.pc), 0);

    set_pc(9);
    bus.stop       = 1;
    bus.endProgram = 1;
    tick();
    clear_inputs();
    chk("halt_parado", int'(bus.parado), 1);
    for (int i = 0; i < 12; i++) begin
      bus.botao = i[1];
      tick();
      chk("halt_pc", int'(bus.pc), 9);
      chk("halt_sinal", int'(bus.sinal), 0);
    end
    bus.botao = 0;
    reset_pulse();
    chk("halt_rst_parado", int'(bus.parado), 0);
    @(negedge clock);

    set_pc(20);
    bus.spc = 1;
    tick();
    clear_inputs();
    chk("spc_pc", int'(bus.pc), 21);
`ifdef CONTEXTO_EN
    chk("spc_salvo", int'(bus.pc_salvo), 21);
    bus.lpc = 1; bus.dado_reg = 50;
    tick();
    clear_inputs();
    chk("lpc_pc", int'(bus.pc), 50);
    bus.nextProgram = 1;
    tick();
    clear_inputs();
    chk("next_pc", int'(bus.pc), 21);
`else
    chk("spc_salvo", int'(bus.pc_salvo), 0);
    bus.lpc = 1; bus.dado_reg = 50;
    tick();
    clear_inputs();
    chk("lpc_pc", int'(bus.pc), 22);
    bus.nextProgram = 1;
    tick();
    clear_inputs();
    chk("next_pc", int'(bus.pc), 23);
    chk("next_salvo", int'(bus.pc_salvo), 0);
`endif

    for (int n = 0; n < 600; n++) begin
      bus.desvio      = 3'($urandom_range(0, 7));
      bus.zero        = 1'($urandom_range(0, 1));
      bus.negativo    = 1'($urandom_range(0, 1));
      bus.imediato    = LE'($urandom_range(0, M - 1));
      bus.dado_reg    = $urandom;
      bus.stop        = ($urandom_range(0, 9) == 0);
      bus.endProgram  = ($urandom_range(0, 79) == 0);
      bus.nextProgram = ($urandom_range(0, 7) == 0);
      bus.lpc         = ($urandom_range(0, 7) == 0);
      bus.spc         = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 2) == 0) bus.botao = ~bus.botao;
      if (m_halt && $urandom_range(0, 5) == 0) reset_pulse();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
